// File: rtl/icache.sv
// Direct-mapped instruction cache with a single outstanding 16-byte line refill.
// Optional hit/miss counters are built in when ICACHE_PERF_EN is defined.
module icache #(
    parameter int LINE_NUM = 64,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_clr,
    output logic              if_hit,
    output logic [31:0]       if_inst,
    output logic              fc_valid,
    output logic [ADDR_W-1:0] fc_addr,
    input  logic              fc_done,
    input  logic [127:0]      fc_line
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] sel);
        logic [31:0] w;
        case (sel)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_t              state_r, state_s;
    logic                drop_r, drop_s;
    logic [LINE_NUM-1:0] valid_r;
    logic [TAG_W-1:0]    tag_r  [LINE_NUM];
    logic [127:0]        data_r [LINE_NUM];
    logic [ADDR_W-1:2]   miss_pc_r, miss_pc_s;
    logic                hit_r, hit_s;
    logic [31:0]         inst_r, inst_s;
    logic                fcv_r, fcv_s;
    logic [ADDR_W-1:0]   fca_r, fca_s;

    logic [IDX_W-1:0]    idx_s, miss_idx_s;
    logic [TAG_W-1:0]    tag_s, miss_tag_s;
    logic                lookup_hit_s, req_s, idle_hit_s, miss_start_s, refill_s, fill_s;
    logic                pc_unused_s;

    // Word alignment makes the two low PC bits meaningless to the cache.
    assign pc_unused_s  = ^if_pc[1:0];

    assign idx_s        = if_pc[4 +: IDX_W];
    assign tag_s        = if_pc[ADDR_W-1 -: TAG_W];
    assign miss_idx_s   = miss_pc_r[4 +: IDX_W];
    assign miss_tag_s   = miss_pc_r[ADDR_W-1 -: TAG_W];
    assign lookup_hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    // A clear suppresses the lookup; the held request is retried afterwards.
    assign req_s        = (state_r == ST_IDLE) && rdy && if_valid && !if_clr;
    assign idle_hit_s   = req_s && lookup_hit_s;
    assign miss_start_s = req_s && !lookup_hit_s;
    assign refill_s     = (state_r == ST_MISS) && fc_done;
    assign fill_s       = refill_s && !drop_r && !if_clr;

    // FSM state and drop flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
        end
    end

    // Next-state logic; refill completion is honoured even while rdy is low
    always_comb begin
        state_s = state_r;
        drop_s  = drop_r;
        case (state_r)
            ST_IDLE: begin
                drop_s = 1'b0;
                if (miss_start_s) begin
                    state_s = ST_MISS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MISS: begin
                if (fc_done) begin
                    state_s = ST_IDLE;
                    drop_s  = 1'b0;
                end else if (if_clr) begin
                    drop_s  = 1'b1;
                end else begin
                    drop_s  = drop_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                drop_s  = 1'b0;
            end
        endcase
    end

    // Output next values: hit pulse, forwarded refill word, refill request
    always_comb begin
        hit_s     = 1'b0;
        inst_s    = inst_r;
        fcv_s     = fcv_r;
        fca_s     = fca_r;
        miss_pc_s = miss_pc_r;
        if (idle_hit_s) begin
            hit_s  = 1'b1;
            inst_s = word_sel(data_r[idx_s], if_pc[3:2]);
        end else if (miss_start_s) begin
            fcv_s     = 1'b1;
            fca_s     = {if_pc[ADDR_W-1:4], 4'b0000};
            miss_pc_s = if_pc[ADDR_W-1:2];
        end else if (refill_s) begin
            fcv_s = 1'b0;
            if (fill_s) begin
                hit_s  = 1'b1;
                inst_s = word_sel(fc_line, miss_pc_r[3:2]);
            end else begin
                hit_s  = 1'b0;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // Registered outputs and latched miss address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_r     <= 1'b0;
            inst_r    <= 32'd0;
            fcv_r     <= 1'b0;
            fca_r     <= {ADDR_W{1'b0}};
            miss_pc_r <= {(ADDR_W-2){1'b0}};
        end else begin
            hit_r     <= hit_s;
            inst_r    <= inst_s;
            fcv_r     <= fcv_s;
            fca_r     <= fca_s;
            miss_pc_r <= miss_pc_s;
        end
    end

    // Valid bits: bulk clear or set on line install
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {LINE_NUM{1'b0}};
        end else if (if_clr) begin
            valid_r <= {LINE_NUM{1'b0}};
        end else if (fill_s) begin
            valid_r[miss_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[miss_idx_s]  <= miss_tag_s;
            data_r[miss_idx_s] <= fc_line;
        end
    end

    assign if_hit   = hit_r;
    assign if_inst  = inst_r;
    assign fc_valid = fcv_r;
    assign fc_addr  = fca_r;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Performance counters, unaffected by cache clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (idle_hit_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (miss_start_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule
